// File: rtl/disp_lr_check.sv
// rtl/disp_lr_check.sv - streaming left-right consistency checker for disparity pairs
//
// Purpose:
//   Checks the left disparity of each pixel against the right disparity recorded
//   d columns earlier in the same row (d = integer part of disp_L). A pixel that
//   passes is forwarded unchanged; a pixel whose reference lies outside the
//   history window or the row, or whose disparities differ by more than THRESH,
//   is replaced and flagged. Two-stage pipeline, one pixel per cycle.
//
// Ports:
//   clk         in   rising-edge clock
//   rst         in   synchronous active-low reset (priority over clken)
//   clken       in   global enable; low freezes every register
//   width       in   row length in pixels (0 treated as 1), sampled at column 0
//   valid_in    in   pixel strobe, accepted when clken is high
//   disp_L      in   left disparity of the current pixel
//   disp_R      in   right disparity of the current pixel
//   valid_out   out  checked pixel valid
//   disp_out    out  checked disparity (or replacement code on reject)
//   reject_out  out  pixel failed the check, qualified by valid_out
//   row_end     out  high with valid_out for the last pixel of a row
//
// Configuration macro:
//   LRC_OCC_FILL_EN  rejected pixels carry the last passing disp_L of the row
//                    instead of INVALID_VAL

module disp_lr_check #(
    parameter int               WIDTH       = 16,
    parameter int               FRAC        = 4,
    parameter int               MAXD        = 128,
    parameter int               THRESH      = 16,
    parameter logic [WIDTH-1:0] INVALID_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clken,
    input  logic [10:0]      width,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] disp_L,
    input  logic [WIDTH-1:0] disp_R,
    output logic             valid_out,
    output logic [WIDTH-1:0] disp_out,
    output logic             reject_out,
    output logic             row_end
);

    localparam int AW = $clog2(MAXD);
    localparam int DW = WIDTH - FRAC;
    localparam int CW = (DW > 11) ? DW : 11;

    // ------------------------------------------------------------------
    // Column tracking
    // ------------------------------------------------------------------
    logic        accept;
    logic [10:0] col;
    logic [10:0] width_r;
    logic [10:0] w_in;
    logic [10:0] cur_w;
    logic        last;

    assign accept = valid_in & clken;
    assign w_in   = (width == 11'd0) ? 11'd1 : width;
    // At column 0 the freshly sampled width already governs this pixel.
    assign cur_w  = (col == 11'd0) ? w_in : width_r;
    assign last   = (col == (cur_w - 11'd1));

    // ------------------------------------------------------------------
    // Right-disparity history and reference selection
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] hist [MAXD];
    logic [DW-1:0]    d;
    logic             d_big;
    logic             d_gt_col;
    logic [AW-1:0]    rd_idx;
    logic [WIDTH-1:0] dr_sel;

    assign d        = disp_L[WIDTH-1:FRAC];
    assign d_big    = (d >> AW) != '0;
    assign d_gt_col = CW'(d) > CW'(col);
    // Modular subtraction on the low bits gives (col - d) mod MAXD directly.
    assign rd_idx   = col[AW-1:0] - d[AW-1:0];
    // d = 0 refers to the pixel being written this cycle, so bypass the buffer.
    assign dr_sel   = (d == '0) ? disp_R : hist[rd_idx];

    always_ff @(posedge clk) begin
        if (rst && accept) begin
            hist[col[AW-1:0]] <= disp_R;
        end
    end

    // ------------------------------------------------------------------
    // Stage 1 datapath registers
    // ------------------------------------------------------------------
    logic             s1_valid;
    logic [WIDTH-1:0] s1_dl;
    logic [WIDTH-1:0] s1_dr;
    logic             s1_bad;
    logic             s1_last;
    logic             s1_first;

    always_ff @(posedge clk) begin
        if (rst && accept) begin
            s1_dl    <= disp_L;
            s1_dr    <= dr_sel;
            s1_bad   <= d_big | d_gt_col;
            s1_last  <= last;
            s1_first <= (col == 11'd0);
        end
    end

    // ------------------------------------------------------------------
    // Stage 2 compare
    // ------------------------------------------------------------------
    logic signed [WIDTH:0] diff;
    logic        [WIDTH:0] adiff;
    logic                  too_far;
    logic                  reject;
    logic [WIDTH-1:0]      rej_val;

    assign diff    = $signed({1'b0, s1_dl}) - $signed({1'b0, s1_dr});
    assign adiff   = diff[WIDTH] ? (~diff + 1'b1) : diff;
    assign too_far = adiff > (WIDTH+1)'(THRESH);
    assign reject  = s1_bad | too_far;

`ifdef LRC_OCC_FILL_EN
    logic [WIDTH-1:0] fill_r;

    // The column-0 pixel sees an empty fill before its own evaluation.
    assign rej_val = s1_first ? '0 : fill_r;

    always_ff @(posedge clk) begin
        if (!rst) begin
            fill_r <= '0;
        end else if (clken && s1_valid) begin
            if (!reject) begin
                fill_r <= s1_dl;
            end else if (s1_first) begin
                fill_r <= '0;
            end
        end
    end
`else
    logic unused_first;

    assign rej_val      = INVALID_VAL;
    assign unused_first = s1_first;
`endif

    // ------------------------------------------------------------------
    // Control state and outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            col        <= 11'd0;
            width_r    <= 11'd1920;
            s1_valid   <= 1'b0;
            valid_out  <= 1'b0;
            disp_out   <= '0;
            reject_out <= 1'b0;
            row_end    <= 1'b0;
        end else if (clken) begin
            s1_valid  <= accept;
            valid_out <= s1_valid;
            if (accept) begin
                if (col == 11'd0) begin
                    width_r <= w_in;
                end
                col <= last ? 11'd0 : (col + 11'd1);
            end
            // Data outputs only change when a real pixel leaves stage 2;
            // bubbles leave the last pixel's values in place.
            if (s1_valid) begin
                disp_out   <= reject ? rej_val : s1_dl;
                reject_out <= reject;
                row_end    <= s1_last;
            end
        end
    end

endmodule

// File: tb/tb_disp_lr_check.sv
// tb/tb_disp_lr_check.sv - directed and stall-sequence bench for disp_lr_check

module tb_disp_lr_check;

    logic        clk;
    logic        rst;
    logic        clken;
    logic [10:0] width;
    logic        valid_in;
    logic [15:0] disp_L;
    logic [15:0] disp_R;
    logic        valid_out;
    logic [15:0] disp_out;
    logic        reject_out;
    logic        row_end;

    int ncmp  = 0;
    int nfail = 0;

`ifdef LRC_OCC_FILL_EN
    localparam logic [15:0] FILL11 = 16'h0040;
`else
    localparam logic [15:0] FILL11 = 16'h0000;
`endif

    disp_lr_check dut (
        .clk        (clk),
        .rst        (rst),
        .clken      (clken),
        .width      (width),
        .valid_in   (valid_in),
        .disp_L     (disp_L),
        .disp_R     (disp_R),
        .valid_out  (valid_out),
        .disp_out   (disp_out),
        .reject_out (reject_out),
        .row_end    (row_end)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: whole-row right-disparity array indexed by true column.
    int          m_col = 0;
    int          m_w   = 1920;
    logic [15:0] row_r [0:2047];
    logic [15:0] fill_m = '0;
    logic        p1_v = 1'b0;
    logic [15:0] p1_out = '0;
    logic        p1_rej = 1'b0;
    logic        p1_re = 1'b0;
    logic        e_v = 1'b0;
    logic [15:0] e_out = '0;
    logic        e_rej = 1'b0;
    logic        e_re = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ncmp++;
        assert (got === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic v, input logic [15:0] o,
                              input logic rj, input logic re);
        chk({tag, ".valid"}, {31'd0, valid_out}, {31'd0, v});
        chk({tag, ".disp"}, {16'd0, disp_out}, {16'd0, o});
        chk({tag, ".reject"}, {31'd0, reject_out}, {31'd0, rj});
        chk({tag, ".row_end"}, {31'd0, row_end}, {31'd0, re});
    endtask

    task automatic model_eval(input logic [15:0] dl, input logic [15:0] dr);
        int d;
        int dref;
        int diff;
        logic rj;
        if (m_col == 0) begin
            m_w    = (width == 11'd0) ? 1 : int'(width);
            fill_m = '0;
        end
        d  = int'(dl) / 16;
        rj = 1'b0;
        if (d >= 128 || d > m_col) begin
            rj = 1'b1;
        end else begin
            dref = (d == 0) ? int'(dr) : int'(row_r[m_col - d]);
            diff = int'(dl) - dref;
            if (diff < 0) diff = -diff;
            if (diff > 16) rj = 1'b1;
        end
`ifdef LRC_OCC_FILL_EN
        p1_out = rj ? fill_m : dl;
        if (!rj) fill_m = dl;
`else
        p1_out = rj ? 16'h0000 : dl;
`endif
        p1_rej = rj;
        p1_re  = (m_col == m_w - 1);
        row_r[m_col] = dr;
        m_col = (m_col == m_w - 1) ? 0 : m_col + 1;
    endtask

    task automatic drive(input logic rn, input logic ce, input logic v,
                         input logic [15:0] dl, input logic [15:0] dr);
        rst = rn; clken = ce; valid_in = v; disp_L = dl; disp_R = dr;
        @(posedge clk);
        if (!rn) begin
            m_col = 0; fill_m = '0; p1_v = 1'b0;
            e_v = 1'b0; e_out = '0; e_rej = 1'b0; e_re = 1'b0;
        end else if (ce) begin
            e_v = p1_v;
            if (p1_v) begin
                e_out = p1_out; e_rej = p1_rej; e_re = p1_re;
            end
            p1_v = v;
            if (v) model_eval(dl, dr);
        end
        #1;
        chk("model.valid", {31'd0, valid_out}, {31'd0, e_v});
        if (e_v) begin
            chk("model.disp", {16'd0, disp_out}, {16'd0, e_out});
            chk("model.reject", {31'd0, reject_out}, {31'd0, e_rej});
            chk("model.row_end", {31'd0, row_end}, {31'd0, e_re});
        end
    endtask

    task automatic thr_row(input string tag, input logic [15:0] dr3, input logic exp_rej);
        for (int c = 0; c < 8; c++) begin
            drive(1, 1, 1, (c == 5) ? 16'h0020 : 16'h0000, (c == 3) ? dr3 : 16'h0000);
            if (c == 6) expect_out(tag, 1'b1, exp_rej ? 16'h0000 : 16'h0020, exp_rej, 1'b0);
        end
    endtask

    task automatic rng_row(input string tag, input logic [15:0] dl500, input logic exp_rej);
        for (int c = 0; c < 512; c++) begin
            drive(1, 1, 1, (c == 500) ? dl500 : 16'h0000, (c == 373) ? 16'h07F0 : 16'h0000);
            if (c == 501) expect_out(tag, 1'b1, exp_rej ? 16'h0000 : dl500, exp_rej, 1'b0);
        end
    endtask

    initial begin
        int          acc;
        int          r;
        logic        ce;
        logic        v;
        logic [15:0] dl;
        logic [15:0] dr;

        rst = 1'b0; clken = 1'b1; width = 11'd8; valid_in = 1'b0; disp_L = '0; disp_R = '0;

        // Reset state
        drive(0, 1, 0, 0, 0);
        drive(0, 1, 0, 0, 0);
        expect_out("reset", 1'b0, 16'h0000, 1'b0, 1'b0);

        // Constant match, width 8, d = 3
        for (int i = 0; i <= 8; i++) begin
            drive(1, 1, i < 8, 16'h0030, 16'h0030);
            if (i == 0)
                chk("const.latency", {31'd0, valid_out}, 32'd0);
            else
                expect_out($sformatf("const.col%0d", i - 1), 1'b1,
                           (i - 1 >= 3) ? 16'h0030 : 16'h0000, i - 1 < 3, i - 1 == 7);
        end

        // Outputs hold while clken is low
        for (int i = 0; i < 3; i++) drive(1, 0, 1, 16'h1234, 16'h0000);
        expect_out("hold", 1'b1, 16'h0030, 1'b0, 1'b1);
        drive(1, 1, 0, 0, 0);
        chk("bubble.valid", {31'd0, valid_out}, 32'd0);

        // width = 0 acts as width 1
        width = 11'd0;
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, i < 3, 16'h0010, 16'h0010);
            if (i >= 1) expect_out("width0", 1'b1, 16'h0000, 1'b1, 1'b1);
        end

        // Threshold edge at col 5, d = 2, reference col 3
        width = 11'd8;
        thr_row("thr.plus16", 16'h0030, 1'b0);
        thr_row("thr.plus17", 16'h0031, 1'b1);
        thr_row("thr.minus17", 16'h000F, 1'b1);
        thr_row("thr.minus16", 16'h0010, 1'b0);

        // Range: d = MAXD rejects, d = MAXD-1 reads across the buffer wrap
        width = 11'd512;
        rng_row("range.d128", 16'h0800, 1'b1);
        rng_row("range.d127", 16'h07F0, 1'b0);

        // Fill behaviour on reject after a pass
        width = 11'd16;
        for (int c = 0; c < 16; c++) begin
            dl = (c == 10 || c == 11) ? 16'h0040 : 16'h0000;
            dr = (c == 6) ? 16'h0040 : ((c == 7) ? 16'h0100 : 16'h0000);
            drive(1, 1, 1, dl, dr);
            if (c == 11) expect_out("fill.pass10", 1'b1, 16'h0040, 1'b0, 1'b0);
            if (c == 12) expect_out("fill.rej11", 1'b1, FILL11, 1'b1, 1'b0);
        end
        drive(1, 1, 1, 16'h0010, 16'h0010);
        drive(1, 1, 0, 0, 0);
        expect_out("fill.col0", 1'b1, 16'h0000, 1'b1, 1'b0);
        for (int c = 1; c < 16; c++) drive(1, 1, 1, 0, 0);
        drive(1, 1, 0, 0, 0);
        drive(1, 1, 0, 0, 0);

        // Stalls and bubbles over three full-width rows
        width = 11'd1920;
        acc = 0;
        for (int n = 0; n < 30000 && acc < 3 * 1920; n++) begin
            ce = ($urandom_range(0, 3) != 0);
            v  = ($urandom_range(0, 4) != 0);
            r  = int'($urandom_range(0, 9));
            if (r == 0)      dl = 16'($urandom_range(0, 65535));
            else if (r == 1) dl = 16'($urandom_range(0, 15));
            else             dl = 16'(32'h0500 + $urandom_range(0, 48) - 24);
            dr = 16'(32'h0500 + $urandom_range(0, 15));
            drive(1, ce, v, dl, dr);
            if (ce && v) acc++;
        end
        chk("stall.budget", acc, 3 * 1920);
        drive(1, 1, 0, 0, 0);
        drive(1, 1, 0, 0, 0);

        // Reset in the middle of a row
        for (int c = 0; c < 700; c++) drive(1, 1, 1, 16'h0000, 16'h0000);
        drive(0, 1, 1, 16'h0030, 16'h0030);
        expect_out("rstmid.after", 1'b0, 16'h0000, 1'b0, 1'b0);
        drive(1, 1, 1, 16'h0030, 16'h0030);
        chk("rstmid.flushed", {31'd0, valid_out}, 32'd0);
        drive(1, 1, 0, 0, 0);
        expect_out("rstmid.col0", 1'b1, 16'h0000, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule

// File: doc/disp_lr_check.md
# disp_lr_check

- Streaming left-right consistency checker on the median-filtered disparity stream (`valid_out`/`disp_L_out`/`disp_R_out` of the median stage).
- For each pixel, compares the left disparity at column x with the right disparity at column x−d, using a circular buffer of recent right disparities.
- Emits one checked disparity per accepted pixel; inconsistent or out-of-range pixels are replaced by an invalid code.
- Sits between the median filter and the output formatter in the stereo SGM pipeline.

## Interface
- `WIDTH`, 16: disparity word width, unsigned fixed point.
- `FRAC`, 4: fractional (subpixel) bits in a disparity word.
- `MAXD`, 128: right-disparity history depth; power of two.
- `THRESH`, 16: max allowed |dL − dR| in raw units (default = 1.0 px).
- `INVALID_VAL`, 0: code emitted for rejected pixels when no fill is configured.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-low reset.
- `clken` input 1: global enable; low freezes all state and outputs.
- `width` input 11: row length in pixels, 1..1920; sampled when column = 0.
- `valid_in` input 1: pixel strobe; accepted only when `clken`=1.
- `disp_L` input WIDTH: left disparity of pixel x.
- `disp_R` input WIDTH: right disparity of pixel x.
- `valid_out` output 1: checked pixel valid.
- `disp_out` output WIDTH: checked disparity.
- `reject_out` output 1: pixel failed the check; qualified by `valid_out`.
- `row_end` output 1: coincides with `valid_out` for the last pixel of a row.

## Operation
- Accept = `valid_in & clken`. Column counter `col` (11 b) increments on accept; after `width_r`−1 it wraps to 0. `width_r` is latched from `width` on an accept at col 0.
- History buffer: MAXD×WIDTH registers. On accept, `disp_R` is written to slot `col mod MAXD`.
- Integer disparity: `d = disp_L >> FRAC`.
- Read rule:
  - d = 0: compare against the current `disp_R` (bypass).
  - Otherwise: compare against slot `(col − d) mod MAXD`, read before the same-cycle write.
- Reject conditions:
  - d ≥ MAXD.
  - d > col (reference pixel lies left of the row start).
  - |disp_L − dR| > THRESH. The difference is computed at WIDTH+1 bits signed, then abs.
- Pass: `disp_out` = `disp_L`, `reject_out` = 0.
- Reject: `disp_out` = INVALID_VAL (or fill, see Configuration), `reject_out` = 1.
- Stale buffer contents are never read: the d > col check covers any column not yet written in the current row. No buffer clear is needed between rows or after reset.
- `row_end` = 1 when the output pixel's column equals `width_r`−1.

## Timing
- Latency is 2 accepted-enable cycles.
  - Stage 1 registers `disp_L`, the selected dR, `col`, and the range flags.
  - Stage 2 registers the compare result onto the outputs.
- Throughput: 1 pixel per cycle. Gaps in `valid_in` propagate as `valid_out`=0 bubbles.
- `clken`=0: counters, buffer, pipeline and outputs hold their values; `valid_out` holds its value (it is not pulsed again).
- Reset (`rst`=0 at a clock edge):
  - `valid_out`=0, `disp_out`=0, `reject_out`=0, `row_end`=0.
  - `col`=0, `width_r`=1920, pipeline valid bits cleared, fill register = 0.
  - Reset takes priority over `clken`.
- Reset mid-row: in-flight pixels are discarded; the next accept is column 0.
- `width`=0 is treated as 1 (every pixel is a row end).
- Simultaneous row wrap and accept: the column-0 pixel of the new row is handled in the same cycle the counter wraps. The new `width_r` takes effect for that pixel.

## Configuration
- `LRC_OCC_FILL_EN` defined:
  - Rejected pixels output the last passing `disp_L` of the current row.
  - The fill register resets to 0 on `rst` and at each column-0 pixel before its own evaluation.
  - `reject_out` is still 1 for filled pixels.
- Not defined: rejected pixels output INVALID_VAL and the fill register is not built.

## Test plan
- Constant match: width=8, disp_L=disp_R=0x0030 (3 px) for all pixels.
  - Cols 0–2 rejected (d > col): out=0, reject=1.
  - Cols 3–7: out=0x0030, reject=0.
  - `row_end` on the 8th output.
  - `valid_out` arrives 2 cycles after each `valid_in`.
- Threshold edge: d=2, col=5, stored dR = dL+16 → pass. The same pixel with dR = dL+17 → reject. Also check a negative difference of −17 → reject.
- Range: disp_L=0x0800 (d=128=MAXD) at col 500 → reject.
  - disp_L=0x07F0 (d=127) at col 500 with a matching dR → pass; confirms the buffer wrap-around read.
- Stall/bubbles: toggle `clken` and `valid_in` pseudo-randomly over 3 rows of width 1920.
  - Outputs must match a reference model pixel-for-pixel.
  - Outputs hold during `clken`=0.
- Reset mid-row: assert `rst`=0 at col 700 for 1 cycle.
  - Next cycle: valid_out=0, disp_out=0.
  - The next accepted pixel is treated as col 0 and is rejected if d>0.
- Fill (`LRC_OCC_FILL_EN`): pass 0x0040 at col 10, then reject at col 11 → out=0x0040, reject=1.
  - At the next row's col 0 with d=1 → out=0.
